// File: rtl/smg_serial_rx.sv
// -----------------------------------------------------------------------------
// smg_serial_rx
// Receive side of the 74HC595 segment-display serial link. Oversamples the
// ds_data/ds_shcp/ds_stcp lines in the clk domain and rebuilds the 16-bit
// shift and storage registers. Each latched {sel,seg} frame is decoded back
// to a hex nibble, and the multi-digit word is reassembled from the frames.
//
// Optional feature macro: SMG_RX_DP_IGNORE_EN
//   defined   : the decimal-point bit is ignored when decoding, so a lit dp
//               is still accepted. seg_out always shows the raw bit.
//   undefined : a lit dp (seg bit7 = 0) fails the table match.
//
// Parameters
//   DIGITS       digits assembled (sel bits [DIGITS-1:0]), 1..4
//   SYNC_STAGES  synchroniser depth on each link line, >= 2
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   ds_data      serial data, sampled on the shcp rising edge
//   ds_shcp      shift clock
//   ds_stcp      storage (latch) clock
//   seg_out      latched segment byte, active-low (bit0=a .. bit6=g, bit7=dp)
//   sel_out      latched digit-select byte, active-low one-hot
//   latch_pulse  1-cycle pulse when seg_out/sel_out update
//   digit_data   assembled word; digit i in [4i+3:4i]
//   digit_valid  1-cycle pulse when digit_data updates
//   decode_err   1-cycle pulse on a rejected frame
//
// FSM states
//   state   | meaning
//   COLLECT | decode latched frames into slots, track which digits were seen
//   PUBLISH | copy slots to digit_data, clear seen mask (one cycle)
// -----------------------------------------------------------------------------
module smg_serial_rx #(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ds_data,
    input  logic                  ds_shcp,
    input  logic                  ds_stcp,
    output logic [7:0]            seg_out,
    output logic [7:0]            sel_out,
    output logic                  latch_pulse,
    output logic [4*DIGITS-1:0]   digit_data,
    output logic                  digit_valid,
    output logic                  decode_err
);

    localparam logic [7:0]        LOW_MASK = 8'((1 << DIGITS) - 1);
    localparam logic [DIGITS-1:0] ALL_SEEN = {DIGITS{1'b1}};

    typedef enum logic {COLLECT, PUBLISH} state_t;

    state_t                state, state_nxt;
    logic [SYNC_STAGES-1:0] data_sync, shcp_sync, stcp_sync;
    logic                  shcp_prev, stcp_prev;
    logic                  data_s, shcp_edge, stcp_edge;
    logic [15:0]           sr;
    logic [7:0]            seg_chk;
    logic                  seg_hit;
    logic [3:0]            seg_nib;
    logic [DIGITS-1:0]     dec_mask;
    logic                  sel_ok, frame_ok;
    logic [DIGITS-1:0]     seen;
    logic [4*DIGITS-1:0]   slots;
    logic                  pend;
    logic                  take_frame, queue_frame, do_publish;

    // Equal-depth synchronisers keep data aligned with its shift clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sync <= '0;
            shcp_sync <= '0;
            stcp_sync <= '0;
            shcp_prev <= 1'b0;
            stcp_prev <= 1'b0;
        end else begin
            data_sync <= {data_sync[SYNC_STAGES-2:0], ds_data};
            shcp_sync <= {shcp_sync[SYNC_STAGES-2:0], ds_shcp};
            stcp_sync <= {stcp_sync[SYNC_STAGES-2:0], ds_stcp};
            shcp_prev <= shcp_sync[SYNC_STAGES-1];
            stcp_prev <= stcp_sync[SYNC_STAGES-1];
        end
    end

    assign data_s    = data_sync[SYNC_STAGES-1];
    assign shcp_edge = shcp_sync[SYNC_STAGES-1] & ~shcp_prev;
    assign stcp_edge = stcp_sync[SYNC_STAGES-1] & ~stcp_prev;

    // Non-blocking update gives the latch the pre-shift sr on coincident edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr          <= 16'hFFFF;
            seg_out     <= 8'hFF;
            sel_out     <= 8'hFF;
            latch_pulse <= 1'b0;
        end else begin
            latch_pulse <= stcp_edge;
            if (shcp_edge)
                sr <= {sr[14:0], data_s};
            if (stcp_edge)
                {sel_out, seg_out} <= sr;
        end
    end

    always_comb begin
        seg_chk = seg_out;
`ifdef SMG_RX_DP_IGNORE_EN
        seg_chk[7] = 1'b1;
`else
        seg_chk[7] = seg_out[7];
`endif
    end

    always_comb begin
        seg_hit = 1'b1;
        seg_nib = 4'h0;
        case (seg_chk)
            8'hC0: seg_nib = 4'h0;
            8'hF9: seg_nib = 4'h1;
            8'hA4: seg_nib = 4'h2;
            8'hB0: seg_nib = 4'h3;
            8'h99: seg_nib = 4'h4;
            8'h92: seg_nib = 4'h5;
            8'h82: seg_nib = 4'h6;
            8'hF8: seg_nib = 4'h7;
            8'h80: seg_nib = 4'h8;
            8'h90: seg_nib = 4'h9;
            8'h88: seg_nib = 4'hA;
            8'h83: seg_nib = 4'hB;
            8'hC6: seg_nib = 4'hC;
            8'hA1: seg_nib = 4'hD;
            8'h86: seg_nib = 4'hE;
            8'h8E: seg_nib = 4'hF;
            default: seg_hit = 1'b0;
        endcase
    end

    // Exactly one active-low select among the used digits, unused bits all high.
    assign dec_mask = ~sel_out[DIGITS-1:0];
    assign sel_ok   = $onehot(dec_mask) && ((sel_out | LOW_MASK) == 8'hFF);
    assign frame_ok = sel_ok && seg_hit;

    always_ff @(posedge clk) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT:
                if (take_frame && frame_ok && ((seen | dec_mask) == ALL_SEEN))
                    state_nxt = PUBLISH;
            PUBLISH:
                state_nxt = COLLECT;
            default:
                state_nxt = COLLECT;
        endcase
    end

    // A latch arriving during PUBLISH is held in pend; seg_out/sel_out stay
    // stable long enough to decode it on the following cycle.
    always_comb begin
        take_frame  = (state == COLLECT) && (latch_pulse || pend);
        queue_frame = (state == PUBLISH) && latch_pulse;
        do_publish  = (state == PUBLISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen        <= '0;
            slots       <= '0;
            pend        <= 1'b0;
            digit_data  <= '0;
            digit_valid <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            pend        <= queue_frame;
            digit_valid <= do_publish;
            decode_err  <= take_frame && !frame_ok;
            if (take_frame && frame_ok) begin
                seen <= seen | dec_mask;
                for (int i = 0; i < DIGITS; i++)
                    if (dec_mask[i])
                        slots[4*i +: 4] <= seg_nib;
            end
            if (do_publish) begin
                digit_data <= slots;
                seen       <= '0;
            end
        end
    end

endmodule
